// File: rtl/dcache_direct_mapped_if.sv
// Main-memory request/response bus used by the data cache.
//   master : cache side. Drives the command channel (valid/rw/addr/tag), the
//            write-beat channel (data_valid/bits/mask) and accepts read beats.
//   slave  : memory side. Drives ready/data_ready and the read beats
//            (resp_valid/resp_data/resp_tag; responses have no backpressure).
interface dcache_direct_mapped_if #(
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_TAG_BITS  = 5
);
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic                       mem_req_rw;
  logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
  logic [MEM_TAG_BITS-1:0]    mem_req_tag;
  logic                       mem_req_data_valid;
  logic                       mem_req_data_ready;
  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
  logic                       mem_resp_valid;
  logic [MEM_DATA_BITS-1:0]   mem_resp_data;
  logic [MEM_TAG_BITS-1:0]    mem_resp_tag;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready,
           mem_resp_valid, mem_resp_data, mem_resp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready,
           mem_resp_valid, mem_resp_data, mem_resp_tag
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache. One line is one
// 128-bit memory beat (four 32-bit words).
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   cpu_req_*       CPU request (addr, re, byte-write mask we, din); a store
//                   wins when re and we are both set; ignored while stall=1
//   cpu_resp_dout   load word; valid in the first stall=0 cycle after a load
//                   was accepted, otherwise holds its last value
//   stall           CPU pipeline freeze, high while a miss is serviced
//   mem             memory bus (master side): command, write beat, read beat
module dcache_direct_mapped #(
  parameter int LINES         = 64,
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_TAG_BITS  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_req_addr,
  input  logic        cpu_req_re,
  input  logic [3:0]  cpu_req_we,
  input  logic [31:0] cpu_req_din,
  output logic [31:0] cpu_resp_dout,
  output logic        stall,
  dcache_direct_mapped_if.master mem
);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = MEM_ADDR_BITS - IDX_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_DATA, S_FILL_REQ, S_FILL_WAIT, S_REFILL_DONE
  } state_t;

  // Storage arrays (no reset) with registered read
  logic [MEM_DATA_BITS-1:0] data_mem [LINES];
  logic [TAG_BITS-1:0]      tag_mem  [LINES];
  logic [MEM_DATA_BITS-1:0] data_rd_reg;
  logic [TAG_BITS-1:0]      tag_rd_reg;

  // Control state
  state_t                   state_reg;
  logic [LINES-1:0]         valid_reg;
  logic [LINES-1:0]         dirty_reg;
  logic                     req_valid_reg;
  logic [31:0]              req_addr_reg;
  logic [3:0]               req_we_reg;
  logic [31:0]              req_din_reg;
  logic [31:0]              dout_reg;
  logic                     cmd_valid_reg;
  logic                     cmd_rw_reg;
  logic [MEM_ADDR_BITS-1:0] cmd_addr_reg;
  logic                     wdata_valid_reg;

  logic                     accept;
  logic [IDX_BITS-1:0]      in_idx;
  logic [IDX_BITS-1:0]      req_idx;
  logic [TAG_BITS-1:0]      req_tag;
  logic [1:0]               req_word;
  logic                     req_store;
  logic                     lookup;
  logic                     tag_match;
  logic                     miss;
  logic                     done;
  logic                     fill_fire;
  logic                     wr_en;
  logic [MEM_DATA_BITS-1:0] wr_data;
  logic [MEM_DATA_BITS-1:0] merged_line;
  logic [31:0]              load_word;

  assign accept    = !stall && (cpu_req_re || (cpu_req_we != 4'b0000));
  assign in_idx    = cpu_req_addr[4 +: IDX_BITS];
  assign req_idx   = req_addr_reg[4 +: IDX_BITS];
  assign req_tag   = req_addr_reg[31 -: TAG_BITS];
  assign req_word  = req_addr_reg[3:2];
  assign req_store = (req_we_reg != 4'b0000);

  assign lookup    = (state_reg == S_IDLE) && req_valid_reg;
  assign tag_match = valid_reg[req_idx] && (tag_rd_reg == req_tag);
  assign miss      = lookup && !tag_match;
  // The request completes either on a lookup hit or right after a refill
  assign done      = (lookup && tag_match) || (state_reg == S_REFILL_DONE);

  assign stall = miss || (state_reg == S_WB_REQ) || (state_reg == S_WB_DATA) ||
                 (state_reg == S_FILL_REQ) || (state_reg == S_FILL_WAIT);

  assign load_word     = data_rd_reg[32*req_word +: 32];
  assign cpu_resp_dout = (done && !req_store) ? load_word : dout_reg;

  // Byte-lane store merge into the selected word of the current line
  genvar gi;
  generate
    for (gi = 0; gi < MEM_DATA_BITS/8; gi++) begin : g_merge
      localparam logic [1:0] WSEL = 2'(gi / 4);
      assign merged_line[8*gi +: 8] =
        (req_word == WSEL && req_we_reg[gi % 4]) ? req_din_reg[8*(gi % 4) +: 8]
                                                 : data_rd_reg[8*gi +: 8];
    end
  endgenerate

  assign fill_fire = (state_reg == S_FILL_WAIT) && mem.mem_resp_valid;
  assign wr_en     = fill_fire || (done && req_store);
  assign wr_data   = fill_fire ? mem.mem_resp_data : merged_line;

  // Array write plus read for the newly accepted request. A store merge can
  // land on the same edge a following request is captured; forwarding the
  // written line keeps store-then-load to one line correct at full rate.
  // During a refill the fill beat is loaded into the read register so the
  // completion cycle sees the new line.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[req_idx] <= wr_data;
    end
    if (fill_fire) begin
      tag_mem[req_idx] <= req_tag;
    end
    if (accept) begin
      data_rd_reg <= (wr_en && (req_idx == in_idx)) ? wr_data : data_mem[in_idx];
      tag_rd_reg  <= tag_mem[in_idx];
    end else if (fill_fire) begin
      data_rd_reg <= mem.mem_resp_data;
    end
  end

  // Control FSM with registered memory-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      valid_reg       <= '0;
      dirty_reg       <= '0;
      req_valid_reg   <= 1'b0;
      req_addr_reg    <= '0;
      req_we_reg      <= '0;
      req_din_reg     <= '0;
      dout_reg        <= '0;
      cmd_valid_reg   <= 1'b0;
      cmd_rw_reg      <= 1'b0;
      cmd_addr_reg    <= '0;
      wdata_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        req_valid_reg <= 1'b1;
        req_addr_reg  <= cpu_req_addr;
        req_we_reg    <= cpu_req_we;
        req_din_reg   <= cpu_req_din;
      end else if (done) begin
        req_valid_reg <= 1'b0;
      end

      if (done && req_store) begin
        dirty_reg[req_idx] <= 1'b1;
      end
      if (done && !req_store) begin
        dout_reg <= load_word;
      end

      case (state_reg)
        S_IDLE: begin
          if (miss) begin
            cmd_valid_reg <= 1'b1;
            if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
              state_reg    <= S_WB_REQ;
              cmd_rw_reg   <= 1'b1;
              cmd_addr_reg <= {tag_rd_reg, req_idx};
            end else begin
              state_reg    <= S_FILL_REQ;
              cmd_rw_reg   <= 1'b0;
              cmd_addr_reg <= req_addr_reg[31:4];
            end
          end
        end
        S_WB_REQ: begin
          if (mem.mem_req_ready) begin
            cmd_valid_reg   <= 1'b0;
            wdata_valid_reg <= 1'b1;
            state_reg       <= S_WB_DATA;
          end
        end
        S_WB_DATA: begin
          if (mem.mem_req_data_ready) begin
            wdata_valid_reg    <= 1'b0;
            dirty_reg[req_idx] <= 1'b0;
            cmd_valid_reg      <= 1'b1;
            cmd_rw_reg         <= 1'b0;
            cmd_addr_reg       <= req_addr_reg[31:4];
            state_reg          <= S_FILL_REQ;
          end
        end
        S_FILL_REQ: begin
          if (mem.mem_req_ready) begin
            cmd_valid_reg <= 1'b0;
            state_reg     <= S_FILL_WAIT;
          end
        end
        S_FILL_WAIT: begin
          if (mem.mem_resp_valid) begin
            valid_reg[req_idx] <= 1'b1;
            dirty_reg[req_idx] <= 1'b0;
            state_reg          <= S_REFILL_DONE;
          end
        end
        S_REFILL_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req_valid      = cmd_valid_reg;
  assign mem.mem_req_rw         = cmd_rw_reg;
  assign mem.mem_req_addr       = cmd_addr_reg;
  assign mem.mem_req_tag        = '0;
  assign mem.mem_req_data_valid = wdata_valid_reg;
  // The victim line was captured at request time and is untouched until the
  // write beat is accepted
  assign mem.mem_req_data_bits  = data_rd_reg;
  assign mem.mem_req_data_mask  = '1;
endmodule

// File: tb/tb_dcache_direct_mapped.sv
module tb_dcache_direct_mapped;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_req_re = 1'b0;
  logic [3:0]  cpu_req_we = '0;
  logic [31:0] cpu_req_din = '0;
  logic [31:0] cpu_resp_dout;
  logic        stall;

  dcache_direct_mapped_if mem_if ();

  dcache_direct_mapped dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req_addr (cpu_req_addr),
    .cpu_req_re   (cpu_req_re),
    .cpu_req_we   (cpu_req_we),
    .cpu_req_din  (cpu_req_din),
    .cpu_resp_dout(cpu_resp_dout),
    .stall        (stall),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model: flat word-addressed memory ----------
  logic [31:0]  ref_mem  [logic [29:0]];
  logic [127:0] back_mem [logic [27:0]];

  function automatic logic [31:0] dflt(input logic [27:0] la, input logic [1:0] w);
    logic [3:0] n;
    n = 4'hA + {2'b00, w};
    if (la == 28'h10) return {8{n}};
    return ({4'b0000, la} * 32'h9E3779B1) ^ {8{2'b01, w}};
  endfunction

  function automatic logic [127:0] back_line(input logic [27:0] la);
    logic [127:0] l;
    if (back_mem.exists(la)) return back_mem[la];
    for (int w = 0; w < 4; w++) l[32*w +: 32] = dflt(la, 2'(w));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] wa);
    logic [127:0] l;
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = back_line(wa[29:2]);
    return l[32*wa[1:0] +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = ref_word({la, 2'(w)});
    return l;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din);
    logic [31:0] v;
    v = ref_word(a[31:2]);
    for (int b = 0; b < 4; b++) if (we[b]) v[8*b +: 8] = din[8*b +: 8];
    ref_mem[a[31:2]] = v;
  endtask

  // ---------------- scoreboard + monitor ----------------------------------
  logic [31:0] exp_q [$];
  logic [31:0] last_dout = '0;
  int          stall_cnt = 0;

  initial begin
    bit pending;
    logic [31:0] e;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 1'b0;
        exp_q.delete();
      end else begin
        if (stall) stall_cnt++;
        if (pending && !stall) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 1, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            check("load_data", cpu_resp_dout, e);
            $display("load done dout=%h exp=%h", cpu_resp_dout, e);
            last_dout = cpu_resp_dout;
          end
          pending = 1'b0;
        end
        if (!stall && cpu_req_re && cpu_req_we == 4'b0000) pending = 1'b1;
      end
    end
  end

  // ---------------- memory model -----------------------------------------
  bit          rand_rdy = 1'b0;
  bit          junk_en = 1'b0;
  int          lat = 3;
  int          hold_cnt = 0;
  int          hold_seen = 0;
  logic [28:0] cmd_log [$];
  logic [127:0] last_wb = '0;
  bit          rd_pending = 1'b0;

  initial begin
    logic [27:0] rd_addr, wb_addr, prev_addr;
    logic        prev_rw;
    int          rd_delay;
    bit          cmd_wait, dat_wait;
    rd_addr = '0; wb_addr = '0; prev_addr = '0; prev_rw = 1'b0;
    rd_delay = 0; cmd_wait = 1'b0; dat_wait = 1'b0;
    mem_if.mem_req_ready      = 1'b0;
    mem_if.mem_req_data_ready = 1'b0;
    mem_if.mem_resp_valid     = 1'b0;
    mem_if.mem_resp_data      = '0;
    mem_if.mem_resp_tag       = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_resp_valid = 1'b0;
      if (reset) begin
        rd_pending = 1'b0;
        cmd_wait = 1'b0;
        dat_wait = 1'b0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_req_data_ready = 1'b0;
      end else begin
        // read beat, or a stray beat the cache must ignore
        if (rd_pending) begin
          if (rd_delay == 0) begin
            mem_if.mem_resp_valid = 1'b1;
            mem_if.mem_resp_data  = back_line(rd_addr);
            mem_if.mem_resp_tag   = 5'($urandom);
            rd_pending = 1'b0;
          end else begin
            rd_delay--;
          end
        end else if (junk_en && $urandom_range(0, 7) == 0) begin
          mem_if.mem_resp_valid = 1'b1;
          mem_if.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        // handshake stability
        if (cmd_wait)
          check("cmd_hold", {mem_if.mem_req_valid, mem_if.mem_req_rw, mem_if.mem_req_addr},
                {1'b1, prev_rw, prev_addr});
        if (dat_wait) check("data_hold", mem_if.mem_req_data_valid, 1'b1);
        if (mem_if.mem_req_valid || mem_if.mem_req_data_valid)
          check("cmd_data_excl", mem_if.mem_req_valid & mem_if.mem_req_data_valid, 1'b0);
        // command channel
        mem_if.mem_req_ready = 1'b0;
        cmd_wait = 1'b0;
        if (mem_if.mem_req_valid) begin
          check("req_tag", mem_if.mem_req_tag, 5'd0);
          if (hold_cnt > 0) begin
            hold_cnt--;
            if (stall) hold_seen++;
          end else begin
            mem_if.mem_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
          if (mem_if.mem_req_ready) begin
            cmd_log.push_back({mem_if.mem_req_rw, mem_if.mem_req_addr});
            $display("mem cmd rw=%0d addr=%h", mem_if.mem_req_rw, mem_if.mem_req_addr);
            if (!mem_if.mem_req_rw) begin
              rd_pending = 1'b1;
              rd_addr    = mem_if.mem_req_addr;
              rd_delay   = rand_rdy ? $urandom_range(0, 4) : lat;
            end else begin
              wb_addr = mem_if.mem_req_addr;
            end
          end else begin
            cmd_wait  = 1'b1;
            prev_addr = mem_if.mem_req_addr;
            prev_rw   = mem_if.mem_req_rw;
          end
        end
        // write-beat channel
        mem_if.mem_req_data_ready = 1'b0;
        dat_wait = 1'b0;
        if (mem_if.mem_req_data_valid) begin
          check("wb_mask", mem_if.mem_req_data_mask, 16'hFFFF);
          mem_if.mem_req_data_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (mem_if.mem_req_data_ready) begin
            check("wb_data", mem_if.mem_req_data_bits, ref_line(wb_addr));
            $display("mem wb addr=%h data=%h", wb_addr, mem_if.mem_req_data_bits);
            back_mem[wb_addr] = mem_if.mem_req_data_bits;
            last_wb = mem_if.mem_req_data_bits;
          end else begin
            dat_wait = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ---------------------------------------------
  task automatic issue(input logic [31:0] a, input logic re, input logic [3:0] we,
                       input logic [31:0] din);
    int n;
    n = 0;
    cpu_req_addr = a; cpu_req_re = re; cpu_req_we = we; cpu_req_din = din;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 300);
    if (stall) check("accept_timeout", stall, 1'b0);
    if (we != 4'b0000) ref_store(a, we, din);
    else exp_q.push_back(ref_word(a[31:2]));
    @(posedge clk);
    #1;
    cpu_req_re = 1'b0;
    cpu_req_we = 4'b0000;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((stall || exp_q.size() != 0) && n < 300);
    if (stall || exp_q.size() != 0) check("quiet_timeout", {stall, 32'(exp_q.size())}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    logic [21:0] tg;
    logic [5:0]  ix;
    logic [5:0]  idx_set [4];
    logic [31:0] a;
    int          k;
    idx_set[0] = 6'h10; idx_set[1] = 6'h11; idx_set[2] = 6'h3F; idx_set[3] = 6'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_mem_valid", mem_if.mem_req_valid, 1'b0);
    check("rst_data_valid", mem_if.mem_req_data_valid, 1'b0);
    check("rst_dout", cpu_resp_dout, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // cold miss on line 0x10
    cmd_log.delete();
    s0 = stall_cnt;
    issue(32'h100, 1'b1, 4'b0000, 32'h0);
    wait_quiet();
    check("t1_cmd_cnt", cmd_log.size(), 1);
    if (cmd_log.size() > 0) check("t1_cmd", cmd_log[0], {1'b0, 28'h10});
    check("t1_stall_cycles", stall_cnt - s0, 6);
    check("t1_dout", last_dout, 32'hAAAAAAAA);

    // back-to-back hits and a byte store
    s0 = stall_cnt;
    issue(32'h104, 1'b1, 4'b0000, 32'h0);
    issue(32'h108, 1'b1, 4'b0000, 32'h0);
    issue(32'h104, 1'b0, 4'b0010, 32'h00005500);
    issue(32'h104, 1'b1, 4'b0000, 32'h0);
    wait_quiet();
    check("t2_no_stall", stall_cnt - s0, 0);
    check("t2_merge", last_dout, 32'hBBBB55BB);

    // conflict miss on a dirty line
    cmd_log.delete();
    issue(32'h500, 1'b1, 4'b0000, 32'h0);
    wait_quiet();
    check("t3_cmd_cnt", cmd_log.size(), 2);
    if (cmd_log.size() > 1) begin
      check("t3_wb_cmd", cmd_log[0], {1'b1, 28'h10});
      check("t3_fill_cmd", cmd_log[1], {1'b0, 28'h50});
    end
    check("t3_wb_word1", last_wb[63:32], 32'hBBBB55BB);
    check("t3_dout", last_dout, dflt(28'h50, 2'd0));

    // command held off by memory for 5 cycles
    hold_cnt = 5;
    hold_seen = 0;
    issue(32'h900, 1'b1, 4'b0000, 32'h0);
    wait_quiet();
    check("t4_hold_cycles", hold_seen, 5);
    check("t4_dout", last_dout, dflt(28'h90, 2'd0));

    // reset while waiting for a fill beat
    lat = 40;
    cmd_log.delete();
    issue(32'hD00, 1'b1, 4'b0000, 32'h0);
    for (int n = 0; n < 50 && cmd_log.size() == 0; n++) @(negedge clk);
    @(posedge clk);
    #2;
    check("t5_pre_stall", stall, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_rst_stall", stall, 1'b0);
    check("t5_rst_mem_valid", mem_if.mem_req_valid, 1'b0);
    ref_mem.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    lat = 3;
    @(posedge clk);
    #1;
    cmd_log.delete();
    issue(32'h100, 1'b1, 4'b0000, 32'h0);
    wait_quiet();
    check("t5_refill_cnt", cmd_log.size(), 1);
    if (cmd_log.size() > 0) check("t5_refill_cmd", cmd_log[0], {1'b0, 28'h10});
    check("t5_dout", last_dout, 32'hAAAAAAAA);

    // random traffic over conflicting lines
    rand_rdy = 1'b1;
    junk_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tg = 22'($urandom_range(0, 3));
      ix = idx_set[$urandom_range(0, 3)];
      a  = {tg, ix, 2'($urandom_range(0, 3)), 2'b00};
      k  = $urandom_range(0, 9);
      if (k < 5) begin
        issue(a, 1'b1, 4'b0000, 32'h0);
      end else if (k < 9) begin
        issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    wait_quiet();
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
